// File: rtl/pong_engine.sv
`default_nettype none
// pong_engine: two-paddle pong core on a GRID_W x GRID_H grid with serve, scoring and game-over.
// Rev 1.0 - initial parametrised release.
module pong_engine #(
  parameter int GRID_W      = 8,
  parameter int GRID_H      = 8,
  parameter int PAD_LEN     = 2,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 4,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H)
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          ball_tick,
  input  logic          pad_tick,
  input  logic          p1_up,
  input  logic          p1_dn,
  input  logic          p2_up,
  input  logic          p2_dn,
  input  logic          start,
  output logic [XW-1:0] ball_x,
  output logic [YW-1:0] ball_y,
  output logic [XW-1:0] pad1_pos,
  output logic [XW-1:0] pad2_pos,
  output logic [3:0]    score1,
  output logic [3:0]    score2,
  output logic [1:0]    state,
  output logic [1:0]    winner,
  output logic          point_pulse
);
  localparam int CW = $clog2(SERVE_DELAY + 1);

  localparam logic [1:0] S_SERVE = 2'b00;
  localparam logic [1:0] S_PLAY  = 2'b01;
  localparam logic [1:0] S_OVER  = 2'b10;

  localparam logic [1:0] DX_NEG  = 2'b11;
  localparam logic [1:0] DX_ZERO = 2'b00;
  localparam logic [1:0] DX_POS  = 2'b01;

  localparam logic [XW-1:0] X_MID    = XW'(GRID_W / 2);
  localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
  localparam logic [XW-1:0] X_ONE    = XW'(1);
  localparam logic [XW-1:0] PAD_INIT = XW'((GRID_W - PAD_LEN) / 2);
  localparam logic [XW-1:0] PAD_MAX  = XW'(GRID_W - PAD_LEN);
  localparam logic [XW-1:0] PAD_SPAN = XW'(PAD_LEN - 1);
  localparam logic [YW-1:0] Y_MID    = YW'(GRID_H / 2);
  localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
  localparam logic [YW-1:0] Y_ONE    = YW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_DELAY - 1);
  localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

  logic [1:0]    state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    dx, dx_n, dx_t;
  logic          dy_neg, dy_neg_n, dy_t;
  logic [XW-1:0] ball_x_n, pad1_n, pad2_n, def_pos, def_end;
  logic [YW-1:0] ball_y_n;
  logic [3:0]    score1_n, score2_n, score1_inc, score2_inc;
  logic [1:0]    winner_n;
  logic          point_n;
  logic          at_top, at_bot, in_row, hit, miss;

  // Defender is chosen from the ball's heading; paddle positions are the pre-edge values.
  assign at_top     = (ball_y == '0) && dy_neg;
  assign at_bot     = (ball_y == Y_MAX) && !dy_neg;
  assign in_row     = at_top || at_bot;
  assign def_pos    = at_top ? pad2_pos : pad1_pos;
  assign def_end    = def_pos + PAD_SPAN;
  assign hit        = (ball_x >= def_pos) && (ball_x <= def_end);
  assign miss       = in_row && !hit;
  assign score1_inc = score1 + 4'd1;
  assign score2_inc = score2 + 4'd1;

  function automatic logic [XW-1:0] pad_step(input logic [XW-1:0] pos, input logic up, input logic dn);
    pad_step = pos;
    if (up && !dn && pos != '0)
      pad_step = pos - X_ONE;
    else if (dn && !up && pos < PAD_MAX)
      pad_step = pos + X_ONE;
  endfunction

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state <= S_SERVE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_SERVE: if (ball_tick && cnt == CNT_LAST) state_n = S_PLAY;
      S_PLAY: begin
        if (ball_tick && miss) begin
          if ((at_top && score1_inc == WIN) || (at_bot && score2_inc == WIN))
            state_n = S_OVER;
          else
            state_n = S_SERVE;
        end
      end
      S_OVER:  if (start) state_n = S_SERVE;
      default: state_n = S_SERVE;
    endcase
  end

  always_comb begin
    ball_x_n = ball_x;
    ball_y_n = ball_y;
    dx_n     = dx;
    dy_neg_n = dy_neg;
    cnt_n    = cnt;
    score1_n = score1;
    score2_n = score2;
    winner_n = winner;
    point_n  = 1'b0;
    pad1_n   = pad1_pos;
    pad2_n   = pad2_pos;
    if (pad_tick && state != S_OVER) begin
      pad1_n = pad_step(pad1_pos, p1_up, p1_dn);
      pad2_n = pad_step(pad2_pos, p2_up, p2_dn);
    end
    // Paddle deflection first, then the side-wall reflection, then the move.
    dx_t = dx;
    dy_t = dy_neg;
    if (in_row) begin
      dy_t = !dy_neg;
      if (ball_x == def_pos)      dx_t = DX_NEG;
      else if (ball_x == def_end) dx_t = DX_POS;
      else                        dx_t = DX_ZERO;
    end
    if (ball_x == '0 && dx_t == DX_NEG)        dx_t = DX_POS;
    else if (ball_x == X_MAX && dx_t == DX_POS) dx_t = DX_NEG;
    case (state)
      S_SERVE: if (ball_tick) cnt_n = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      S_PLAY: begin
        if (ball_tick) begin
          if (miss) begin
            ball_x_n = X_MID;
            ball_y_n = Y_MID;
            cnt_n    = '0;
            dx_n     = DX_ZERO;
            point_n  = 1'b1;
            if (at_top) begin
              score1_n = score1_inc;
              dy_neg_n = 1'b1;
              if (score1_inc == WIN) winner_n = 2'b01;
            end else begin
              score2_n = score2_inc;
              dy_neg_n = 1'b0;
              if (score2_inc == WIN) winner_n = 2'b10;
            end
          end else begin
            dx_n     = dx_t;
            dy_neg_n = dy_t;
            if (dx_t == DX_NEG)      ball_x_n = ball_x - X_ONE;
            else if (dx_t == DX_POS) ball_x_n = ball_x + X_ONE;
            ball_y_n = dy_t ? ball_y - Y_ONE : ball_y + Y_ONE;
          end
        end
      end
      S_OVER: begin
        if (start) begin
          score1_n = '0;
          score2_n = '0;
          winner_n = 2'b00;
          dx_n     = DX_ZERO;
          dy_neg_n = 1'b1;
          cnt_n    = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      ball_x      <= X_MID;
      ball_y      <= Y_MID;
      dx          <= DX_ZERO;
      dy_neg      <= 1'b1;
      cnt         <= '0;
      score1      <= '0;
      score2      <= '0;
      winner      <= 2'b00;
      point_pulse <= 1'b0;
      pad1_pos    <= PAD_INIT;
      pad2_pos    <= PAD_INIT;
    end else begin
      ball_x      <= ball_x_n;
      ball_y      <= ball_y_n;
      dx          <= dx_n;
      dy_neg      <= dy_neg_n;
      cnt         <= cnt_n;
      score1      <= score1_n;
      score2      <= score2_n;
      winner      <= winner_n;
      point_pulse <= point_n;
      pad1_pos    <= pad1_n;
      pad2_pos    <= pad2_n;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pong_engine.sv
`default_nettype none
// tb_pong_engine: directed stimulus with a scoreboard queue and a decoupled output monitor.
// Rev 1.0
module tb_pong_engine;
  localparam logic [1:0] SERVE = 2'b00;
  localparam logic [1:0] PLAY  = 2'b01;
  localparam logic [1:0] OVER  = 2'b10;

  localparam logic [4:0] M_BALL  = 5'b00001;
  localparam logic [4:0] M_PAD   = 5'b00010;
  localparam logic [4:0] M_SCORE = 5'b00100;
  localparam logic [4:0] M_ST    = 5'b01000;
  localparam logic [4:0] M_PP    = 5'b10000;
  localparam logic [4:0] M_ALL   = 5'b11111;

  // Hand-computed ball path from reset with idle paddles (ticks 1..16).
  localparam int SX [16] = '{4, 4, 4, 4, 4, 4, 4, 4, 5, 6, 7, 6, 5, 4, 3, 2};
  localparam int SY [16] = '{4, 4, 4, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 6};

  typedef struct {
    string      name;
    logic [4:0] mask;
    logic [2:0] bx, by, p1, p2;
    logic [3:0] s1, s2;
    logic [1:0] st, win;
    logic       pp;
  } exp_t;

  logic       sysclk = 1'b0;
  logic       reset, ball_tick, pad_tick, p1_up, p1_dn, p2_up, p2_dn, start;
  logic [2:0] ball_x, ball_y, pad1_pos, pad2_pos;
  logic [3:0] score1, score2;
  logic [1:0] state, winner;
  logic       point_pulse;

  exp_t exp_q[$];
  logic mon_pending = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pong_engine dut (
    .sysclk(sysclk), .reset(reset), .ball_tick(ball_tick), .pad_tick(pad_tick),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .pad1_pos(pad1_pos), .pad2_pos(pad2_pos),
    .score1(score1), .score2(score2), .state(state), .winner(winner),
    .point_pulse(point_pulse)
  );

  always #5 sysclk = ~sysclk;

  function automatic exp_t mk(input string n, input logic [4:0] m, input int bx, input int by,
                              input int p1, input int p2, input int s1, input int s2,
                              input logic [1:0] st, input int win, input logic pp);
    exp_t e;
    e.name = n; e.mask = m;
    e.bx = 3'(bx); e.by = 3'(by); e.p1 = 3'(p1); e.p2 = 3'(p2);
    e.s1 = 4'(s1); e.s2 = 4'(s2); e.st = st; e.win = 2'(win); e.pp = pp;
    return e;
  endfunction

  task automatic cmp(input string n, input string f, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%0d required=%0d at %0t", n, f, act, req, $time);
    end
  endtask

  // Monitor: compares whenever the stimulus has flagged the current edge as observable.
  always @(posedge sysclk or posedge reset) begin
    #1;
    if (mon_pending) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL no_expectation actual=empty_queue required=entry at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.mask[0]) begin cmp(e.name, "ball_x", 8'(ball_x), 8'(e.bx)); cmp(e.name, "ball_y", 8'(ball_y), 8'(e.by)); end
        if (e.mask[1]) begin cmp(e.name, "pad1", 8'(pad1_pos), 8'(e.p1)); cmp(e.name, "pad2", 8'(pad2_pos), 8'(e.p2)); end
        if (e.mask[2]) begin cmp(e.name, "score1", 8'(score1), 8'(e.s1)); cmp(e.name, "score2", 8'(score2), 8'(e.s2)); end
        if (e.mask[3]) begin cmp(e.name, "state", 8'(state), 8'(e.st)); cmp(e.name, "winner", 8'(winner), 8'(e.win)); end
        if (e.mask[4]) cmp(e.name, "point_pulse", 8'(point_pulse), 8'(e.pp));
      end
    end
  end

  // One clock cycle of stimulus, entered and left on a negative edge.
  task automatic cyc(input logic bt, input logic pt, input logic [3:0] btn, input logic st,
                     input logic chk, input exp_t e);
    ball_tick = bt; pad_tick = pt; start = st;
    {p1_up, p1_dn, p2_up, p2_dn} = btn;
    if (chk) exp_q.push_back(e);
    mon_pending = chk;
    @(negedge sysclk);
    ball_tick = 1'b0; pad_tick = 1'b0; start = 1'b0; mon_pending = 1'b0;
  endtask

  task automatic async_reset_check();
    #1;
    exp_q.push_back(mk("async_reset", M_ALL, 4, 4, 3, 3, 0, 0, SERVE, 0, 1'b0));
    mon_pending = 1'b1;
    #1 reset = 1'b1;
    #2 mon_pending = 1'b0;
    @(negedge sysclk);
    reset = 1'b0;
  endtask

  task automatic serve_seq(input int n, input bit pad_probe);
    for (int t = 0; t < n; t++) begin
      if (pad_probe && t == 8)
        cyc(1'b1, 1'b1, 4'b0010, 1'b0, 1'b1,
            mk("hit_vs_same_cycle_pad", M_BALL | M_ST | M_PP | M_PAD, 5, 1, 3, 2, 0, 0, PLAY, 0, 1'b0));
      else
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1,
            mk($sformatf("serve_t%0d", t + 1), M_BALL | M_ST | M_PP, SX[t], SY[t], 0, 0, 0, 0,
               (t < 3) ? SERVE : PLAY, 0, 1'b0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t none;
    none = mk("-", 5'b0, 0, 0, 0, 0, 0, 0, SERVE, 0, 1'b0);
    reset = 1'b1; ball_tick = 1'b0; pad_tick = 1'b0; start = 1'b0;
    p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
    repeat (2) @(negedge sysclk);
    reset = 1'b0;

    cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, mk("reset_values", M_ALL, 4, 4, 3, 3, 0, 0, SERVE, 0, 1'b0));

    // Serve, pad2 hit (with a same-cycle pad2 move), wall bounce at x=7, pad1 hit.
    serve_seq(16, 1'b1);

    // Mid-play asynchronous reset, then the serve sequence must repeat exactly.
    async_reset_check();
    serve_seq(16, 1'b0);

    // P2 walks to the left wall, then misses seven times.
    async_reset_check();
    for (int i = 1; i <= 3; i++)
      cyc(1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, mk("pad2_left", M_PAD, 0, 0, 3, 3 - i, 0, 0, SERVE, 0, 1'b0));
    for (int k = 1; k <= 7; k++) begin
      for (int t = 1; t <= 9; t++) begin
        if (t == 5)
          cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1,
              mk($sformatf("reserve_up_%0d", k), M_BALL | M_ST, 4, 3, 0, 0, 0, 0, PLAY, 0, 1'b0));
        else if (t == 9)
          cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1,
              mk($sformatf("point_%0d", k), M_ALL, 4, 4, 3, 0, k, 0,
                 (k == 7) ? OVER : SERVE, (k == 7) ? 1 : 0, 1'b1));
        else
          cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, none);
      end
      cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1,
          mk($sformatf("pulse_end_%0d", k), M_PP, 0, 0, 0, 0, 0, 0, SERVE, 0, 1'b0));
    end

    // Game over: ticks and buttons ignored, everything frozen.
    for (int i = 0; i < 20; i++)
      cyc(1'b1, 1'b1, 4'b0101, 1'b0, 1'b1, mk("over_hold", M_ALL, 4, 4, 3, 0, 7, 0, OVER, 1, 1'b0));
    cyc(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, mk("restart", M_ALL, 4, 4, 3, 0, 0, 0, SERVE, 0, 1'b0));
    serve_seq(5, 1'b0);

    // Paddle range limits.
    async_reset_check();
    for (int i = 1; i <= 10; i++)
      cyc(1'b0, 1'b1, 4'b0100, 1'b0, 1'b1,
          mk("pad1_right_limit", M_PAD, 0, 0, (3 + i > 6) ? 6 : 3 + i, 3, 0, 0, SERVE, 0, 1'b0));
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b1, 4'b1100, 1'b0, 1'b1, mk("pad1_both_hold", M_PAD, 0, 0, 6, 3, 0, 0, SERVE, 0, 1'b0));
    cyc(1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, mk("pad1_up_one", M_PAD, 0, 0, 5, 3, 0, 0, SERVE, 0, 1'b0));

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pong_engine.md
Name: pong_engine

Overview:
- Parametrised successor of the fixed 8x8 ping-pong game core: one grid of GRID_W columns x GRID_H rows, two paddles, scoring and game-over.
- Single sysclk domain; ball and paddle motion advance on one-cycle enable pulses (ball_tick, pad_tick) from upstream tick generators. The block uses no derived clocks.
- Outputs are coordinates and scores only. The LED row/column multiplexer downstream converts them to drive patterns.

Parameters:
- GRID_W, 8, number of columns (x axis); power of two, >=4
- GRID_H, 8, number of rows (y axis); power of two, >=4
- PAD_LEN, 2, paddle length in cells; 2..GRID_W/2
- WIN_SCORE, 7, points needed to win; 1..15
- SERVE_DELAY, 4, ball_ticks the ball rests at centre before each serve; >=1
- Derived: XW=clog2(GRID_W), YW=clog2(GRID_H)

Ports:
- sysclk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ball_tick  in  1  one-cycle enable for a ball step
- pad_tick  in  1  one-cycle enable for a paddle step
- p1_up, p1_dn, p2_up, p2_dn  in  1 each  level buttons (already synchronised)
- start  in  1  pulse; restarts the game from OVER
- ball_x  out  XW  ball column
- ball_y  out  YW  ball row
- pad1_pos, pad2_pos  out  XW  leftmost column of each paddle
- score1, score2  out  4 each  scores
- state  out  2  00 SERVE, 01 PLAY, 10 OVER
- winner  out  2  00 none, 01 P1, 10 P2
- point_pulse  out  1  high for one cycle when a point is scored

Behaviour:
- Interface: one clock (sysclk); reset is asynchronous and active-high (reset). All state registers clear on reset assertion, with no clock required.
- Reset values:
  - ball at centre (GRID_W/2, GRID_H/2)
  - pad1_pos = pad2_pos = (GRID_W-PAD_LEN)/2
  - scores 0, state SERVE, serve counter 0, winner 00, point_pulse 0
  - direction dx=0, dy=-1
- Geometry: P2 paddle occupies row 0 and P1 paddle occupies row GRID_H-1. Each paddle covers columns pos..pos+PAD_LEN-1.
- Paddles: act on pad_tick in SERVE and PLAY only; frozen in OVER.
  - up alone: pos-1 if pos>0, otherwise hold.
  - dn alone: pos+1 if pos<GRID_W-PAD_LEN, otherwise hold.
  - up and dn together: hold.
- SERVE:
  - Ball is held at centre.
  - Each ball_tick increments the serve counter.
  - On the SERVE_DELAY-th tick: counter clears and state becomes PLAY. The ball does not move on that tick.
- PLAY, on each ball_tick (dx in {-1,0,+1}, dy in {-1,+1}):
  1. Paddle-row test. It applies when (y==0 and dy=-1) or (y==GRID_H-1 and dy=+1). Compare against the defending paddle's position as registered before this cycle; a same-cycle pad_tick update is not seen.
     - Hit: dy is negated.
     - dx = -1 for the leftmost cell, +1 for the rightmost cell, 0 for interior cells.
  2. Miss:
     - The opponent's score increments and point_pulse=1 for that cycle.
     - Ball recentres; serve counter clears.
     - New direction: dx=0, dy toward the player who conceded.
     - Next state: OVER if the new score == WIN_SCORE, otherwise SERVE.
     - No movement on this tick.
  3. Wall test, applied after step 1: if x==0 and dx=-1, dx becomes +1; if x==GRID_W-1 and dx=+1, dx becomes -1.
  4. Move: x+=dx, y+=dy. Ball coordinates never leave the grid.
- Ordering: the corner case (paddle row and wall in the same tick) applies the paddle rule, then the wall rule, then the move.
- OVER:
  - Ball held at centre; winner holds 01 or 10.
  - Scores hold; ticks are ignored.
  - start: scores clear, winner=00, state SERVE, dx=0, dy=-1.
  - start in any other state is ignored.
- ball_tick and pad_tick may coincide; both are processed in the same cycle.
- All outputs are registered. An input tick affects the outputs one cycle later.

Test Plan:
- Serve and paddle hit: reset, default parameters, no buttons, 8 ball_ticks.
  - Required: state=01 after tick 4; ball (4,3),(4,2),(4,1),(4,0) on ticks 5..8.
  - Tick 9: x=4 is pad2's rightmost cell, so ball goes to (5,1), dx=+1, dy=+1.
- Miss: reset; p2_up held for 3 pad_ticks so pad2_pos=0; run 9 ball_ticks.
  - Required: score1=1, one-cycle point_pulse, state=00, ball (4,4), dy=-1, score2=0.
- Wall bounce: force a play in which the ball reaches x=7 with dx=+1 mid-field.
  - Required: the next step lands at x=6 and y advances by dy.
- Paddle limits: p1_dn held 10 pad_ticks.
  - Required: pad1_pos=6 and holds.
  - Then p1_up and p1_dn both held for 3 ticks: pad1_pos stays 6.
  - In OVER, paddle ticks leave the positions unchanged.
- Win and restart: let P2 miss 7 times.
  - Required: score1=7, state=10, winner=01, ball frozen at (4,4) through 20 ticks.
  - start pulse: scores 0, winner 00, state 00.
- Asynchronous reset mid-PLAY: assert reset between clock edges.
  - Required: all outputs take their reset values immediately, with no clock edge.
  - After release, the serve sequence is identical to the first scenario.
